// File: rtl/vac_pkg.sv
// Shared types and default constants for the vector apply/check harness.
package vac_pkg;
  typedef enum logic [1:0] {IDLE, APPLY, REPORT, DONE} vac_state_t;

  localparam logic [9:0] DEF_POLY = 10'h204;
  localparam logic [9:0] DEF_SEED = 10'h000;
endpackage

// File: rtl/vac_misr.sv
// Multiple-input signature register: shift left, fold in POLY on MSB, XOR in the response.
module vac_misr #(
  parameter int               OUT_W = 10,
  parameter logic [OUT_W-1:0] POLY  = 10'h204,
  parameter logic [OUT_W-1:0] SEED  = '0
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             en,
  input  logic             clr,
  input  logic [OUT_W-1:0] din,
  output logic [OUT_W-1:0] sig
);
  always_ff @(posedge clk) begin
    if (!rst_n || clr)
      sig <= SEED;
    else if (en)
      sig <= {sig[OUT_W-2:0], 1'b0} ^ (sig[OUT_W-1] ? POLY : '0) ^ din;
  end
endmodule

// File: rtl/vector_apply_checker.sv
// Applies stimulus vectors to a combinational DUT, samples after a settle window,
// compares under a mask, counts mismatches and compacts responses into a MISR.
module vector_apply_checker
  import vac_pkg::*;
#(
  parameter int               IN_W   = 20,
  parameter int               OUT_W  = 10,
  parameter int               SETTLE = 2,
  parameter int               CNT_W  = 16,
  parameter logic [OUT_W-1:0] MASK   = {OUT_W{1'b1}},
  parameter logic [OUT_W-1:0] POLY   = DEF_POLY,
  parameter logic [OUT_W-1:0] SEED   = DEF_SEED
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             clr,
  input  logic             vec_valid,
  output logic             vec_ready,
  input  logic [IN_W-1:0]  vec_stim,
  input  logic [OUT_W-1:0] vec_exp,
  input  logic             vec_last,
  output logic [IN_W-1:0]  dut_in,
  input  logic [OUT_W-1:0] dut_out,
  output logic             res_valid,
  input  logic             res_ready,
  output logic [OUT_W-1:0] res_data,
  output logic             res_pass,
  output logic [CNT_W-1:0] err_count,
  output logic [OUT_W-1:0] signature,
  output logic             done
);
  localparam int SC_W = (SETTLE > 0) ? $clog2(SETTLE + 1) : 1;

  vac_state_t       state, nxt;
  logic [SC_W-1:0]  settle_cnt;
  logic [OUT_W-1:0] exp_r;
  logic             last_r;
  logic             sample, cmp, accept;

  assign vec_ready = (state == IDLE);
  assign accept    = vec_ready && vec_valid && !clr;
  assign sample    = (state == APPLY) && (settle_cnt == '0) && !clr;
  assign cmp       = ((dut_out ^ exp_r) & MASK) == '0;

  always_ff @(posedge clk) begin
    if (!rst_n) state <= IDLE;
    else        state <= nxt;
  end

  always_comb begin
    nxt = state;
    if (clr) nxt = IDLE;
    else begin
      case (state)
        IDLE:    if (vec_valid) nxt = APPLY;
        APPLY:   if (settle_cnt == '0) nxt = REPORT;
        REPORT:  if (res_ready) nxt = last_r ? DONE : IDLE;
        DONE:    nxt = DONE;
        default: nxt = IDLE;
      endcase
    end
  end

  // dut_in survives clr so the DUT is not disturbed by a counter clear
  always_ff @(posedge clk) begin
    if (!rst_n)      dut_in <= '0;
    else if (accept) dut_in <= vec_stim;
  end

  always_ff @(posedge clk) begin
    if (!rst_n || clr) begin
      exp_r      <= '0;
      last_r     <= 1'b0;
      settle_cnt <= '0;
      res_valid  <= 1'b0;
      res_data   <= '0;
      res_pass   <= 1'b0;
      err_count  <= '0;
      done       <= 1'b0;
    end else begin
      case (state)
        IDLE: if (vec_valid) begin
          exp_r      <= vec_exp;
          last_r     <= vec_last;
          settle_cnt <= SC_W'(SETTLE);
        end
        APPLY: begin
          if (settle_cnt == '0) begin
            res_data  <= dut_out;
            res_pass  <= cmp;
            res_valid <= 1'b1;
            if (!cmp && err_count != '1) err_count <= err_count + 1'b1;
          end else begin
            settle_cnt <= settle_cnt - 1'b1;
          end
        end
        REPORT: if (res_ready) begin
          res_valid <= 1'b0;
          if (last_r) done <= 1'b1;
        end
        default: ;
      endcase
    end
  end

  vac_misr #(.OUT_W(OUT_W), .POLY(POLY), .SEED(SEED)) u_misr (
    .clk   (clk),
    .rst_n (rst_n),
    .en    (sample),
    .clr   (clr),
    .din   (dut_out & MASK),
    .sig   (signature)
  );
endmodule

// File: tb/tb_vector_apply_checker.sv
// Drives two checkers (full mask / 3FE mask with 2-bit counter) in lockstep against
// a behavioural 20->10 DUT model and a scoreboard of pass/count/signature.
module tb_vector_apply_checker;
  logic        clk = 1'b0;
  logic        rst_n, clr, vec_valid, vec_last, res_ready;
  logic [19:0] vec_stim;
  logic [9:0]  vec_exp;

  logic        vr_a, rv_a, rp_a, dn_a;
  logic [19:0] di_a;
  logic [9:0]  do_a, rd_a, sg_a;
  logic [15:0] ec_a;
  logic        vr_b, rv_b, rp_b, dn_b;
  logic [19:0] di_b;
  logic [9:0]  do_b, rd_b, sg_b;
  logic [1:0]  ec_b;

  int n_chk = 0, n_fail = 0;
  int m_err_a, m_err_b;
  logic [9:0] m_sig_a, m_sig_b;

  always #5 clk = ~clk;

  function automatic logic [9:0] dut_model(input logic [19:0] x);
    int p = $countones(x);
    return 10'h210 ^ 10'(p * 6);
  endfunction

  // signature = sig * x mod (x^10 + POLY), plus the masked response
  function automatic logic [9:0] misr_next(input logic [9:0] s, input logic [9:0] d);
    int v = int'(s) * 2;
    if (v >= 1024) v = (v - 1024) ^ 'h204;
    return 10'(v) ^ d;
  endfunction

  assign do_a = dut_model(di_a);
  assign do_b = dut_model(di_b);

  vector_apply_checker u_a (
    .clk(clk), .rst_n(rst_n), .clr(clr), .vec_valid(vec_valid), .vec_ready(vr_a),
    .vec_stim(vec_stim), .vec_exp(vec_exp), .vec_last(vec_last), .dut_in(di_a),
    .dut_out(do_a), .res_valid(rv_a), .res_ready(res_ready), .res_data(rd_a),
    .res_pass(rp_a), .err_count(ec_a), .signature(sg_a), .done(dn_a));

  vector_apply_checker #(.CNT_W(2), .MASK(10'h3FE)) u_b (
    .clk(clk), .rst_n(rst_n), .clr(clr), .vec_valid(vec_valid), .vec_ready(vr_b),
    .vec_stim(vec_stim), .vec_exp(vec_exp), .vec_last(vec_last), .dut_in(di_b),
    .dut_out(do_b), .res_valid(rv_b), .res_ready(res_ready), .res_data(rd_b),
    .res_pass(rp_b), .err_count(ec_b), .signature(sg_b), .done(dn_b));

  task automatic model_clear();
    m_err_a = 0; m_err_b = 0; m_sig_a = '0; m_sig_b = '0;
  endtask

  // Offer one vector, check latency and result, hold backpressure for `hold` cycles.
  task automatic run_vec(input logic [19:0] stim, input logic [9:0] exp_v,
                         input logic last, input int hold);
    logic [9:0] out = dut_model(stim);
    logic pa = (out == exp_v);
    logic pb = ((out & 10'h3FE) == (exp_v & 10'h3FE));
    int lat = 0;
    if (!pa && m_err_a < 65535) m_err_a++;
    if (!pb && m_err_b < 3) m_err_b++;
    m_sig_a = misr_next(m_sig_a, out);
    m_sig_b = misr_next(m_sig_b, out & 10'h3FE);

    vec_stim = stim; vec_exp = exp_v; vec_last = last; vec_valid = 1'b1; res_ready = 1'b0;
    n_chk++; if (vr_a !== 1'b1 || vr_b !== 1'b1) begin
      n_fail++; $display("FAIL vec_ready_idle got %b/%b want 1", vr_a, vr_b); end
    @(negedge clk);
    vec_valid = 1'b0;
    n_chk++; if (di_a !== stim || di_b !== stim) begin
      n_fail++; $display("FAIL dut_in_drive got %h/%h want %h", di_a, di_b, stim); end
    while (lat < 10) begin
      @(negedge clk); lat++;
      if (rv_a) break;
    end
    n_chk++; if (lat != 3 || rv_b !== 1'b1) begin
      n_fail++; $display("FAIL latency got %0d (b valid %b) want 3", lat, rv_b); end
    n_chk++; if (rd_a !== out || rd_b !== out) begin
      n_fail++; $display("FAIL res_data got %h/%h want %h", rd_a, rd_b, out); end
    n_chk++; if (rp_a !== pa || rp_b !== pb) begin
      n_fail++; $display("FAIL res_pass got %b/%b want %b/%b", rp_a, rp_b, pa, pb); end
    n_chk++; if (ec_a !== 16'(m_err_a) || ec_b !== 2'(m_err_b)) begin
      n_fail++; $display("FAIL err_count got %0d/%0d want %0d/%0d", ec_a, ec_b, m_err_a, m_err_b); end
    n_chk++; if (sg_a !== m_sig_a || sg_b !== m_sig_b) begin
      n_fail++; $display("FAIL signature got %h/%h want %h/%h", sg_a, sg_b, m_sig_a, m_sig_b); end
    for (int i = 0; i < hold; i++) begin
      @(negedge clk);
      n_chk++; if (rv_a !== 1'b1 || rd_a !== out || rp_a !== pa || vr_a !== 1'b0 || di_a !== stim) begin
        n_fail++; $display("FAIL backpressure cyc %0d got v%b d%h p%b r%b in%h want v1 d%h p%b r0 in%h",
                           i, rv_a, rd_a, rp_a, vr_a, di_a, out, pa, stim); end
    end
    res_ready = 1'b1;
    @(negedge clk);
    res_ready = 1'b0;
    n_chk++; if (rv_a !== 1'b0 || dn_a !== last || vr_a !== !last || dn_b !== last) begin
      n_fail++; $display("FAIL post_handshake got v%b done%b rdy%b want v0 done%b rdy%b",
                         rv_a, dn_a, vr_a, last, !last); end
  endtask

  task automatic test_reset();
    rst_n = 1'b0; clr = 1'b0; vec_valid = 1'b0; vec_last = 1'b0; res_ready = 1'b0;
    vec_stim = '0; vec_exp = '0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    model_clear();
    n_chk++; if (di_a !== '0 || rv_a !== 1'b0 || ec_a !== '0 || sg_a !== '0 || vr_a !== 1'b1 || dn_a !== 1'b0
                 || rd_a !== '0 || rp_a !== 1'b0 || ec_b !== '0 || sg_b !== '0) begin
      n_fail++; $display("FAIL reset got in%h v%b e%0d s%h r%b d%b", di_a, rv_a, ec_a, sg_a, vr_a, dn_a); end
  endtask

  task automatic test_pass();     run_vec(20'h00000, 10'h210, 1'b0, 0); endtask
  task automatic test_mismatch(); run_vec(20'h00000, 10'h211, 1'b0, 0); endtask

  task automatic test_backpressure();
    logic [19:0] s = 20'($urandom);
    run_vec(s, dut_model(s), 1'b0, 5);
  endtask

  task automatic test_random();
    for (int i = 0; i < 12; i++) begin
      logic [19:0] s = 20'($urandom);
      logic [9:0] e = dut_model(s);
      if ($urandom_range(0, 1)) e = e ^ 10'(1 << $urandom_range(0, 9));
      run_vec(s, e, 1'b0, $urandom_range(0, 2));
    end
  endtask

  task automatic test_saturation();
    clr = 1'b1; @(negedge clk); clr = 1'b0;
    model_clear();
    for (int i = 0; i < 5; i++) begin
      logic [19:0] s = 20'($urandom);
      run_vec(s, dut_model(s) ^ 10'h002, 1'b0, 0);
    end
    n_chk++; if (ec_b !== 2'd3 || ec_a !== 16'd5) begin
      n_fail++; $display("FAIL saturation got %0d/%0d want 5/3", ec_a, ec_b); end
  endtask

  task automatic test_last();
    run_vec(20'h80020, 10'h21C, 1'b1, 0);
    vec_stim = 20'h12345; vec_exp = '0; vec_valid = 1'b1;
    repeat (3) @(negedge clk);
    vec_valid = 1'b0;
    n_chk++; if (dn_a !== 1'b1 || vr_a !== 1'b0 || di_a !== 20'h80020 || rv_a !== 1'b0) begin
      n_fail++; $display("FAIL done_hold got d%b r%b in%h v%b want d1 r0 in80020 v0", dn_a, vr_a, di_a, rv_a); end
  endtask

  task automatic test_clr();
    clr = 1'b1; vec_valid = 1'b1; vec_stim = 20'h0ABCD; vec_exp = 10'h000;
    @(negedge clk);
    clr = 1'b0; vec_valid = 1'b0;
    model_clear();
    n_chk++; if (vr_a !== 1'b1 || ec_a !== '0 || sg_a !== '0 || dn_a !== 1'b0 || di_a !== 20'h80020
                 || rv_a !== 1'b0 || ec_b !== '0) begin
      n_fail++; $display("FAIL clr got r%b e%0d s%h d%b in%h want r1 e0 s000 d0 in80020",
                         vr_a, ec_a, sg_a, dn_a, di_a); end
    run_vec(20'h00003, dut_model(20'h00003), 1'b0, 0);
  endtask

  task automatic test_reset_midflight();
    vec_stim = 20'h00FF0; vec_exp = '0; vec_last = 1'b0; vec_valid = 1'b1;
    @(negedge clk);
    vec_valid = 1'b0; rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    model_clear();
    repeat (5) @(negedge clk);
    n_chk++; if (rv_a !== 1'b0 || di_a !== '0 || vr_a !== 1'b1 || ec_a !== '0 || sg_a !== '0) begin
      n_fail++; $display("FAIL midflight_reset got v%b in%h r%b e%0d s%h", rv_a, di_a, vr_a, ec_a, sg_a); end
  endtask

  initial begin
    test_reset();
    test_pass();
    test_mismatch();
    test_backpressure();
    test_random();
    test_saturation();
    test_last();
    test_clr();
    test_reset_midflight();
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
